// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply engine: FSM states,
// width helpers and the flat result index used by the read port.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Smallest width that can hold values 0..value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    // Address width that never collapses to zero bits for a 1x1 grid.
    function automatic int addr_width(input int cells);
        return (clog2(cells) < 1) ? 1 : clog2(cells);
    endfunction

    // Row-major position of cell (row, col) in the result space.
    function automatic int cell_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the output-stationary array. Operands and
// their valid tags move one cell right (a) or down (b) per clock, while the
// product is folded into a local accumulator whenever both tags are set.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              a_valid_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              a_valid_out,
    output logic              b_valid_out,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] a_wide_s;
    logic [2*DATA_W-1:0] b_wide_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [ACC_W-1:0]    prod_ext;

    // Full-width product, extended to the accumulator per the job's operand mode.
    always_comb begin
        a_wide_s = {{DATA_W{a_in[DATA_W-1]}}, a_in};
        b_wide_s = {{DATA_W{b_in[DATA_W-1]}}, b_in};
        prod_s   = a_wide_s * b_wide_s;
        prod_u   = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
        prod_ext = signed_mode ? ACC_W'($signed(prod_s)) : ACC_W'(prod_u);
    end

    // Forward operands and tags to the neighbouring cells.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_out       <= '0;
            b_out       <= '0;
            a_valid_out <= 1'b0;
            b_valid_out <= 1'b0;
        end else begin
            a_out       <= a_in;
            b_out       <= b_in;
            a_valid_out <= a_valid_in;
            b_valid_out <= b_valid_in;
        end
    end

    // Accumulate only on tagged operands; clear wins at the start of a fresh job.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (a_valid_in && b_valid_in) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic engine computing C = A*B on a ROWS x COLS grid.
// Holds the job FSM, step/drain counters, operand skew lines and the
// registered random-access result port.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K_W    = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             start,
    input  logic [K_W-1:0]                   k_len,
    input  logic                             signed_mode,
    input  logic                             accumulate,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ROWS*DATA_W-1:0]           a_vec,
    input  logic [COLS*DATA_W-1:0]           b_vec,
    output logic                             busy,
    output logic                             done,
    input  logic [addr_width(ROWS*COLS)-1:0] rd_addr,
    output logic [ACC_W-1:0]                 rd_data
);

    localparam int CELLS   = ROWS * COLS;
    localparam int ADDR_W  = addr_width(CELLS);
    localparam int DRAIN_W = clog2(ROWS + COLS + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(ROWS + COLS - 1);
    localparam logic [ADDR_W:0]    CELLS_LIMIT = (ADDR_W + 1)'(CELLS);

    state_t             state;
    state_t             next_state;
    logic [K_W-1:0]     k_len_q;
    logic [K_W-1:0]     step_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               mode_q;
    logic               start_ok;
    logic               step_ok;
    logic               clear_acc;

    logic [DATA_W-1:0] a_bus  [ROWS][COLS+1];
    logic              a_vbus [ROWS][COLS+1];
    logic [DATA_W-1:0] b_bus  [ROWS+1][COLS];
    logic              b_vbus [ROWS+1][COLS];
    logic [ACC_W-1:0]  acc_cells [CELLS];

    assign step_ok   = in_valid & in_ready;
    assign clear_acc = start_ok & ~accumulate;

    // Job state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status decode; a start is only honoured while not busy.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_ok   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) begin
                    start_ok   = 1'b1;
                    next_state = (k_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (step_cnt == k_len_q - K_W'(1))) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Job parameters latched on start, accepted-step and drain counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_len_q   <= '0;
            mode_q    <= 1'b0;
            step_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_ok) begin
                k_len_q  <= k_len;
                mode_q   <= signed_mode;
                step_cnt <= '0;
            end else if (step_ok) begin
                step_cnt <= step_cnt + K_W'(1);
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Row r of A enters the array r cycles late so it meets the matching B element.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DATA_W-1:0] a_pipe [r+1];
        logic              a_tag  [r+1];

        // Skew line for one A row; bubbles travel as tag 0.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int s = 0; s <= r; s++) begin
                    a_pipe[s] <= '0;
                    a_tag[s]  <= 1'b0;
                end
            end else begin
                a_pipe[0] <= a_vec[r*DATA_W +: DATA_W];
                a_tag[0]  <= step_ok;
                for (int s = 1; s <= r; s++) begin
                    a_pipe[s] <= a_pipe[s-1];
                    a_tag[s]  <= a_tag[s-1];
                end
            end
        end

        assign a_bus[r][0]  = a_pipe[r];
        assign a_vbus[r][0] = a_tag[r];
    end

    // Column c of B enters the array c cycles late, mirroring the A skew.
    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [DATA_W-1:0] b_pipe [c+1];
        logic              b_tag  [c+1];

        // Skew line for one B column; bubbles travel as tag 0.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int s = 0; s <= c; s++) begin
                    b_pipe[s] <= '0;
                    b_tag[s]  <= 1'b0;
                end
            end else begin
                b_pipe[0] <= b_vec[c*DATA_W +: DATA_W];
                b_tag[0]  <= step_ok;
                for (int s = 1; s <= c; s++) begin
                    b_pipe[s] <= b_pipe[s-1];
                    b_tag[s]  <= b_tag[s-1];
                end
            end
        end

        assign b_bus[0][c]  = b_pipe[c];
        assign b_vbus[0][c] = b_tag[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .CLK         (CLK),
                .RST         (RST),
                .clear       (clear_acc),
                .signed_mode (mode_q),
                .a_in        (a_bus[r][c]),
                .b_in        (b_bus[r][c]),
                .a_valid_in  (a_vbus[r][c]),
                .b_valid_in  (b_vbus[r][c]),
                .a_out       (a_bus[r][c+1]),
                .b_out       (b_bus[r+1][c]),
                .a_valid_out (a_vbus[r][c+1]),
                .b_valid_out (b_vbus[r+1][c]),
                .acc         (acc_cells[cell_index(r, c, COLS)])
            );
        end
    end

    // Registered result read; addresses past the grid read as zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < CELLS_LIMIT) begin
            rd_data <= acc_cells[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: directed and random jobs, a job-level
// reference model of C and of the busy/done/ready timeline, plus literal
// expectations for the hand-computable cases.
module tb_systolic_mm_engine;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int K_W    = 8;
    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = 4;
    localparam int MAX_K  = 16;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic                   start = 1'b0;
    logic [K_W-1:0]         k_len = '0;
    logic                   signed_mode = 1'b0;
    logic                   accumulate = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] a_vec = '0;
    logic [COLS*DATA_W-1:0] b_vec = '0;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      rd_addr = '0;
    logic [ACC_W-1:0]       rd_data;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc = 0;
    int start_edge, last_edge, done_edge;
    logic cmp_en = 1'b0;

    logic [DATA_W-1:0] a_job [MAX_K][ROWS];
    logic [DATA_W-1:0] b_job [MAX_K][COLS];

    // Reference model state
    logic             m_busy = 1'b0;
    logic             m_ready = 1'b0;
    logic             m_done = 1'b0;
    logic             m_mode = 1'b0;
    int               m_steps = 0;
    int               m_drain = 0;
    logic [ACC_W-1:0] m_c [CELLS];
    logic             rd_chk = 1'b0;
    logic [ACC_W-1:0] exp_rd = '0;
    logic             take_start;

    systolic_mm_engine #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .K_W    (K_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .accumulate  (accumulate),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .busy        (busy),
        .done        (done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 CLK = ~CLK;

    // Edge counter used for latency measurements.
    always @(posedge CLK) cyc++;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, cyc);
        end
    endtask

    // One product term of C, extended per operand mode and wrapped to ACC_W.
    function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y, input logic sm);
        longint px, py;
        if (sm) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'(x);
            py = longint'(y);
        end
        return ACC_W'(px * py);
    endfunction

    // Job-level model: C updated when a step is accepted, timeline from the job rules.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_done  = 1'b0;
            m_mode  = 1'b0;
            m_steps = 0;
            m_drain = 0;
            rd_chk  = 1'b1;
            exp_rd  = '0;
            foreach (m_c[i]) m_c[i] = '0;
        end else begin
            take_start = start && !m_busy;
            rd_chk     = !m_busy && !take_start;
            exp_rd     = (int'(rd_addr) < CELLS) ? m_c[rd_addr] : '0;
            if (take_start) begin
                m_mode = signed_mode;
                if (!accumulate) foreach (m_c[i]) m_c[i] = '0;
                if (k_len == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_done  = 1'b0;
                    m_busy  = 1'b1;
                    m_ready = 1'b1;
                    m_steps = int'(k_len);
                end
            end else if (m_ready) begin
                if (in_valid) begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            m_c[r*COLS+c] = m_c[r*COLS+c] +
                                mac_term(a_vec[r*DATA_W +: DATA_W], b_vec[c*DATA_W +: DATA_W], m_mode);
                    m_steps--;
                    if (m_steps == 0) begin
                        m_ready = 1'b0;
                        m_drain = ROWS + COLS;
                    end
                end
            end else if (m_busy) begin
                m_drain--;
                if (m_drain == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of DUT status and settled results against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            check_output("in_ready", in_ready, m_ready);
            check_output("busy", busy, m_busy);
            check_output("done", done, m_done);
            if (rd_chk) check_output("rd_data", rd_data, exp_rd);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_identity();
        for (int k = 0; k < ROWS; k++) begin
            for (int r = 0; r < ROWS; r++) a_job[k][r] = (r == k) ? 16'd1 : 16'd0;
            for (int c = 0; c < COLS; c++) b_job[k][c] = DATA_W'(k*COLS + c + 1);
        end
    endtask

    task automatic fill_const(input int k_steps, input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv);
        for (int k = 0; k < k_steps; k++) begin
            for (int r = 0; r < ROWS; r++) a_job[k][r] = av;
            for (int c = 0; c < COLS; c++) b_job[k][c] = bv;
        end
    endtask

    // Runs one job: start pulse, k steps with the chosen bubble pattern, then wait for done.
    task automatic apply_stimulus(input int k, input logic sm, input logic accum, input int bubble_mode, input logic poke);
        int   idx, guard;
        logic accepted;
        start       = 1'b1;
        k_len       = K_W'(k);
        signed_mode = sm;
        accumulate  = accum;
        in_valid    = 1'b0;
        step();
        start_edge = cyc;
        last_edge  = cyc;
        start      = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < k && guard < 1000) begin
            case (bubble_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            if (in_valid) begin
                for (int r = 0; r < ROWS; r++) a_vec[r*DATA_W +: DATA_W] = a_job[idx][r];
                for (int c = 0; c < COLS; c++) b_vec[c*DATA_W +: DATA_W] = b_job[idx][c];
            end else begin
                a_vec = {$urandom, $urandom};
                b_vec = {$urandom, $urandom};
            end
            if (poke && guard == 1) begin
                start = 1'b1;
                k_len = 8'd1;
            end else begin
                start = 1'b0;
            end
            rd_addr  = ADDR_W'($urandom_range(0, CELLS-1));
            accepted = in_valid && in_ready;
            step();
            if (accepted) begin
                idx++;
                last_edge = cyc;
            end
            guard++;
        end
        if (guard >= 1000) check_output("load_timeout", idx, k);
        start    = 1'b0;
        in_valid = 1'b0;
        guard    = 0;
        while (!done && guard < 300) begin
            step();
            guard++;
        end
        check_output("done_seen", done, 1);
        done_edge = cyc;
    endtask

    task automatic read_expect(input string name, input int addr, input logic [ACC_W-1:0] expected);
        rd_addr = ADDR_W'(addr);
        step();
        check_output(name, rd_data, expected);
    endtask

    task automatic read_all();
        for (int i = 0; i < CELLS; i++) begin
            rd_addr = ADDR_W'(i);
            step();
        end
    endtask

    // Directed scenarios followed by random jobs.
    initial begin
        repeat (3) @(posedge CLK);
        #1;
        cmp_en = 1'b1;
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_ready", in_ready, 0);
        check_output("reset_rd", rd_data, 0);
        RST = 1'b0;
        step();

        $display("[TB] identity job");
        fill_identity();
        apply_stimulus(4, 1'b0, 1'b0, 0, 1'b0);
        check_output("ident_latency", done_edge - start_edge, 12);
        for (int i = 0; i < CELLS; i++) read_expect("ident_c", i, ACC_W'(i + 1));

        $display("[TB] signed and unsigned all-ones job");
        fill_const(3, 16'hFFFF, 16'h0002);
        apply_stimulus(3, 1'b1, 1'b0, 0, 1'b0);
        check_output("signed_latency", done_edge - start_edge, 11);
        for (int i = 0; i < CELLS; i += 5) read_expect("signed_c", i, 40'hFF_FFFF_FFFA);
        apply_stimulus(3, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < CELLS; i += 5) read_expect("unsigned_c", i, 40'h5_FFFA);

        $display("[TB] identity job with bubbles");
        fill_identity();
        apply_stimulus(4, 1'b0, 1'b0, 1, 1'b0);
        check_output("bubble_drain", done_edge - last_edge, ROWS + COLS);
        for (int i = 0; i < CELLS; i += 3) read_expect("bubble_c", i, ACC_W'(i + 1));

        $display("[TB] accumulate across calls");
        apply_stimulus(4, 1'b0, 1'b1, 0, 1'b0);
        for (int i = 0; i < CELLS; i += 3) read_expect("accum_c", i, ACC_W'(2 * (i + 1)));
        apply_stimulus(4, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < CELLS; i += 3) read_expect("reclear_c", i, ACC_W'(i + 1));

        $display("[TB] zero-length job and start while busy");
        apply_stimulus(0, 1'b0, 1'b0, 0, 1'b0);
        check_output("kzero_latency", done_edge - start_edge, 0);
        for (int i = 0; i < CELLS; i += 5) read_expect("kzero_c", i, 0);
        apply_stimulus(4, 1'b0, 1'b0, 0, 1'b1);
        check_output("poke_latency", done_edge - start_edge, 12);
        for (int i = 0; i < CELLS; i += 3) read_expect("poke_c", i, ACC_W'(i + 1));

        $display("[TB] reset in the middle of a load");
        start    = 1'b1;
        k_len    = 8'd4;
        accumulate = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            for (int r = 0; r < ROWS; r++) a_vec[r*DATA_W +: DATA_W] = a_job[k][r];
            for (int c = 0; c < COLS; c++) b_vec[c*DATA_W +: DATA_W] = b_job[k][c];
            step();
        end
        RST = 1'b1;
        #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_ready", in_ready, 0);
        check_output("rst_rd", rd_data, 0);
        in_valid = 1'b0;
        step();
        step();
        RST = 1'b0;
        read_expect("rst_c5", 5, 0);
        read_expect("rst_c15", 15, 0);
        apply_stimulus(4, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < CELLS; i += 3) read_expect("after_rst_c", i, ACC_W'(i + 1));

        $display("[TB] random jobs");
        for (int j = 0; j < 10; j++) begin
            int k;
            k = $urandom_range(1, MAX_K);
            for (int s = 0; s < k; s++) begin
                for (int r = 0; r < ROWS; r++) a_job[s][r] = DATA_W'($urandom);
                for (int c = 0; c < COLS; c++) b_job[s][c] = DATA_W'($urandom);
            end
            apply_stimulus(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b0);
            read_all();
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised output-stationary systolic matrix-multiply engine: computes C = A·B (ROWS×K times K×COLS) on a ROWS×COLS grid of MAC cells. It replaces the fixed 4×4, ROM-fed, gated-clock array with a single-clock engine that has runtime K length, signed/unsigned mode, accumulate-across-calls mode, a valid/ready input stream, internal operand skewing and a random-access result read port. It sits between the host data path (ROM/UART loaders) and the result display/BCD logic.

## Interface
- ROWS, 4, PE rows (A vector length, ≥1)
- COLS, 4, PE columns (B vector length, ≥1)
- DATA_W, 16, operand width
- ACC_W, 40, accumulator/result width (≥ 2*DATA_W)
- K_W, 8, width of k_len
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a job when idle or done
- k_len  in  K_W  number of K steps, sampled on accepted start
- signed_mode  in  1  1 = two's-complement operands, sampled on start
- accumulate  in  1  1 = keep previous C instead of clearing, sampled on start
- in_valid  in  1  a_vec/b_vec hold one K step
- in_ready  out  1  engine accepts a K step
- a_vec  in  ROWS*DATA_W  column k of A; element r at [r*DATA_W +: DATA_W]
- b_vec  in  COLS*DATA_W  row k of B; element c at [c*DATA_W +: DATA_W]
- busy  out  1  job in progress
- done  out  1  results complete and stable
- rd_addr  in  clog2(ROWS*COLS)  result index r*COLS+c
- rd_data  out  ACC_W  C[r][c]

## Operation
- FSM: IDLE → LOAD → DRAIN → DONE; DONE → LOAD on start.
- IDLE/DONE + start: latch k_len, signed_mode, accumulate; clear all accumulators unless accumulate=1; clear done; enter LOAD (k_len=0: go directly to DONE, clearing per accumulate).
- start while busy: ignored.
- LOAD: in_ready=1; step accepted on in_valid&in_ready; step counter increments; on the k_len-th accepted step go to DRAIN.
- Skew: a element r delayed r cycles, b element c delayed c cycles; each operand carries a valid tag. Bubble cycles (in_valid=0) inject tag 0; a PE accumulates only when its tag is 1.
- PE: a passes right, b passes down, one register each; acc += a*b, product sign/zero-extended per latched mode to ACC_W; wraps modulo 2^ACC_W.
- DRAIN: fixed ROWS+COLS cycle counter, then DONE.
- busy = LOAD|DRAIN; done = DONE state.
- Read port: always active; out-of-range address returns 0; during busy returns partial sums.

## Timing
- Reset values: in_ready=0, busy=0, done=0, rd_data=0, all accumulators 0, FSM IDLE.
- start accepted at edge S → busy=1, in_ready=1 after S.
- Last step accepted at edge E → in_ready=0 after E; done=1 after edge E+ROWS+COLS.
- Minimum job latency (no bubbles): k_len+ROWS+COLS cycles from start edge to done.
- k_len=0: done=1 after the start edge.
- rd_data: registered, 1-cycle latency from rd_addr.
- RST mid-job: immediate return to reset state; partial results discarded.
- done holds until next accepted start or RST.

## Structure
- Shared package/include systolic_pkg: FSM state encodings, index helper (r*COLS+c), clog2 function.
- Sub-module systolic_pe: one MAC cell (a/b/valid pass-through registers, accumulator, clear, mode); engine instantiates ROWS×COLS via generate.
- Engine holds FSM, step/drain counters, skew shift registers, read mux.

## Test plan
- Identity: A=I4, B=[1..16] row-major, k_len=4 → C=B; done exactly 12 cycles after start (no bubbles).
- Signed: signed_mode=1, A all 16'hFFFF, B all 16'h0002, k_len=3 → every C=-6 (40'hFF_FFFF_FFFA); same with signed_mode=0 → 0x5_FFFA.
- Bubbles: identity job with in_valid toggled 1/0 each cycle → same C, done ROWS+COLS cycles after last accepted step.
- Accumulate: run identity job, then restart with accumulate=1 same data → C=2·B; restart accumulate=0 → C=B.
- k_len=0 and start during busy: done after one cycle, all C=0; start pulse in LOAD ignored (step count unaffected).
- Reset mid-LOAD after 2 steps: all outputs 0, rd_data of any address 0, new job completes correctly.
